hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed two-port EX/DM data-collision detector.
- Tracks every in-flight register write from the ID/EX register through WB in a shift-register scoreboard.
- Per read port: produces a forwarding-source select, and raises a load-use bubble when the youngest producer's data is not yet available.
- Sits beside the control decoder in ID; drives the PC/IF-ID enables and the ID/EX clear.

Parameters:
- STAGES, 3: tracked slots after ID (1=EX, 2=DM, 3=WB).
- REG_BITS, 5: register index width.
- READ_PORTS, 2: number of ID read ports checked.
- SEL_BITS, 2: select width; must satisfy 2^SEL_BITS > STAGES.
- LOAD_LAT, 2: slot index from which load data is forwardable.
- CNT_BITS, 16: width of the bubble counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: global advance enable.
- flush, input, 1: squash the instruction in ID (branch/jump taken).
- issue_w_en, input, 1: ID instruction writes a register.
- issue_req_w, input, REG_BITS: destination register of the ID instruction.
- issue_is_load, input, 1: ID instruction is a load.
- rd_req, input, READ_PORTS*REG_BITS: packed source registers; port p = bits [p*REG_BITS +: REG_BITS].
- rd_used, input, READ_PORTS: port p actually consumes its operand.
- fwd_sel, output, READ_PORTS*SEL_BITS: per port, 0 = register file, k = producer in slot k.
- bubble, output, 1: load-use stall request.
- pending_mask, output, STAGES: valid bits of slots 1..STAGES.
- bubble_cnt, output, CNT_BITS: saturating count of stalled cycles.

Behaviour:
- Slot contents: each slot 1..STAGES holds {valid, req_w, is_load}.
- Reset: all valids=0, bubble_cnt=0. Outputs follow combinationally: fwd_sel=0, bubble=0, pending_mask=0.
- Advance (clk edge with en=1): slot[k+1] <= slot[k] for k=1..STAGES-1. Slot STAGES retires.
- Slot 1 load: slot[1] <= {issue_w_en && issue_req_w!=0 && !bubble && !flush, issue_req_w, issue_is_load}.
  - A bubble or flush therefore inserts a null entry.
- Hold: en=0 freezes every slot and the counter.
- Match rule: port p matches slot k when rd_used[p] && valid[k] && req_w[k]==rd_req[p] && rd_req[p]!=0.
  - Youngest wins: pick the lowest k (WAW case).
- Availability: avail(k) = LOAD_LAT if is_load[k], else 1.
- Selection and stall, per port (combinational, same cycle as inputs):
  - No match: fwd_sel_p=0.
  - Match at k with k >= avail(k): fwd_sel_p=k.
  - Match at k with k < avail(k): fwd_sel_p=0 and bubble=1.
  - bubble = OR over all ports.
- Only the youngest match is considered. An older available copy never masks a younger unavailable one.
- Flush with bubble: flush wins the insert (null). Bubble is still reported combinationally; the caller gates it with flush.
- bubble_cnt increments on each en=1 edge with bubble=1 && !flush. It saturates at all-ones.
- Register 0 is never tracked and never matched.
- Reset mid-operation clears all slots immediately (asynchronously). The first post-reset edge loads slot 1 normally.
- Latency: fwd_sel and bubble are pure combinational outputs of the current slots and ports. The scoreboard updates one edge later.

Test Plan:
- ALU r8 issued, then next-cycle reader of r8 on port 0 -> fwd_sel[1:0]=1, bubble=0. One cycle later a reader of r8 -> fwd_sel=2.
- Load r9 issued, next-cycle reader of r9 on port 1 -> bubble=1, fwd_sel=0, bubble_cnt 0->1. Next edge: null in slot 1, load in slot 2 -> bubble=0, fwd_sel[3:2]=2.
- Load r5 in slot 2 and ALU r5 in slot 1, reader r5 -> fwd_sel=1 (youngest), bubble=0.
- Write to r0 issued, reader r0, rd_used=1 -> pending_mask[0]=0, fwd_sel=0, bubble=0.
- Load r3 issued, with flush=1 on the same edge -> slot 1 null, later r3 readers get fwd_sel=0. With en=0 for 5 cycles the slots and bubble_cnt are unchanged.
- rst pulsed asynchronously mid-clock with 3 valid slots -> pending_mask=3'b000 and bubble_cnt=0 before the next edge. With CNT_BITS=4, forcing 20 stall cycles -> bubble_cnt=15.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write tracker producing per-port forwarding selects and load-use bubbles
module hazard_scoreboard #(
  parameter int STAGES     = 3,
  parameter int REG_BITS   = 5,
  parameter int READ_PORTS = 2,
  parameter int SEL_BITS   = 2,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           flush,
  input  logic                           issue_w_en,
  input  logic [REG_BITS-1:0]            issue_req_w,
  input  logic                           issue_is_load,
  input  logic [READ_PORTS*REG_BITS-1:0] rd_req,
  input  logic [READ_PORTS-1:0]          rd_used,
  output logic [READ_PORTS*SEL_BITS-1:0] fwd_sel,
  output logic                           bubble,
  output logic [STAGES-1:0]              pending_mask,
  output logic [CNT_BITS-1:0]            bubble_cnt
);
  logic [STAGES:1]       valid_q, valid_d, load_q, load_d;
  logic [REG_BITS-1:0]   req_q [1:STAGES];
  logic [REG_BITS-1:0]   req_d [1:STAGES];
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [SEL_BITS-1:0]   sel;
  logic                  stall;
  assign pending_mask = valid_q;
  assign bubble_cnt   = cnt_q;
  // per port, scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    fwd_sel = '0;
    bubble  = 1'b0;
    sel     = '0;
    stall   = 1'b0;
    for (int p = 0; p < READ_PORTS; p++) begin
      sel   = '0;
      stall = 1'b0;
      for (int k = STAGES; k >= 1; k--) begin
        if (rd_used[p] && valid_q[k] && rd_req[p*REG_BITS +: REG_BITS] != '0 &&
            req_q[k] == rd_req[p*REG_BITS +: REG_BITS]) begin
          sel   = SEL_BITS'(k);
          stall = load_q[k] && (k < LOAD_LAT);
        end
      end
      fwd_sel[p*SEL_BITS +: SEL_BITS] = stall ? '0 : sel;
      bubble = bubble | stall;
    end
  end
  // shift the scoreboard on advance; a bubble or flush drops a null entry into slot 1
  always_comb begin
    valid_d = valid_q;
    load_d  = load_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    if (en) begin
      valid_d[1] = issue_w_en && issue_req_w != '0 && !bubble && !flush;
      load_d[1]  = issue_is_load;
      req_d[1]   = issue_req_w;
      for (int k = 2; k <= STAGES; k++) begin
        valid_d[k] = valid_q[k-1];
        load_d[k]  = load_q[k-1];
        req_d[k]   = req_q[k-1];
      end
      cnt_d = (bubble && !flush && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      load_q  <= '0;
      req_q   <= '{default: '0};
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      load_q  <= load_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard against a queue-based model
module tb_hazard_scoreboard;
  localparam int ST = 3, RB = 5, RP = 2, SB = 2, LL = 2, CB = 4;
  localparam int CMAX = (1 << CB) - 1;
  logic clk = 0, rst = 0, en = 0, flush = 0, issue_w_en = 0, issue_is_load = 0;
  logic [RB-1:0] issue_req_w = '0;
  logic [RP*RB-1:0] rd_req = '0;
  logic [RP-1:0] rd_used = '0;
  logic [RP*SB-1:0] fwd_sel;
  logic bubble;
  logic [ST-1:0] pending_mask;
  logic [CB-1:0] bubble_cnt;
  typedef struct {bit v; bit [RB-1:0] r; bit ld;} ent_t;
  ent_t q[$];
  int mcnt = 0, vecs = 0, errs = 0;
  logic [RP*SB-1:0] e_sel;
  logic e_bub;
  logic [ST-1:0] e_mask;

  hazard_scoreboard #(.STAGES(ST), .REG_BITS(RB), .READ_PORTS(RP), .SEL_BITS(SB),
                      .LOAD_LAT(LL), .CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .issue_w_en(issue_w_en),
    .issue_req_w(issue_req_w), .issue_is_load(issue_is_load), .rd_req(rd_req),
    .rd_used(rd_used), .fwd_sel(fwd_sel), .bubble(bubble),
    .pending_mask(pending_mask), .bubble_cnt(bubble_cnt));

  always #5 clk = ~clk;

  function automatic void mreset();
    q.delete();
    repeat (ST) q.push_back('{v: 1'b0, r: '0, ld: 1'b0});
    mcnt = 0;
  endfunction

  function automatic void meval();
    e_sel = '0;
    e_bub = 1'b0;
    e_mask = '0;
    foreach (q[i]) if (q[i].v) e_mask[i] = 1'b1;
    for (int p = 0; p < RP; p++) begin
      logic [RB-1:0] r;
      r = rd_req[p*RB +: RB];
      for (int i = 0; i < q.size(); i++) begin
        if (rd_used[p] && r != 0 && q[i].v && q[i].r == r) begin
          int age, need;
          age = i + 1;
          need = q[i].ld ? LL : 1;
          if (age >= need) e_sel[p*SB +: SB] = SB'(age);
          else e_bub = 1'b1;
          break;
        end
      end
    end
  endfunction

  task automatic set_in(input bit e, input bit f, input bit w, input int wr, input bit ld,
                        input int r0, input int r1, input bit [1:0] u);
    @(negedge clk);
    en = e; flush = f; issue_w_en = w; issue_req_w = RB'(wr); issue_is_load = ld;
    rd_req = {RB'(r1), RB'(r0)}; rd_used = u;
    #1;
    meval();
  endtask

  task automatic tick();
    bit b;
    meval();
    b = e_bub;
    @(posedge clk);
    if (en) begin
      if (b && !flush && mcnt < CMAX) mcnt++;
      q.push_front('{v: (issue_w_en && issue_req_w != 0 && !b && !flush), r: issue_req_w, ld: issue_is_load});
      void'(q.pop_back());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1;
    set_in(0, 0, 1, 8, 0, 8, 8, 2'b11);
    vecs++; if (fwd_sel !== '0) begin errs++; $display("FAIL reset_fwd_sel: got %0h expected 0", fwd_sel); end
    vecs++; if (bubble !== 1'b0) begin errs++; $display("FAIL reset_bubble: got %0b expected 0", bubble); end
    vecs++; if (pending_mask !== '0) begin errs++; $display("FAIL reset_mask: got %0b expected 0", pending_mask); end
    vecs++; if (bubble_cnt !== '0) begin errs++; $display("FAIL reset_cnt: got %0d expected 0", bubble_cnt); end
    rst = 0;
    mreset();
  endtask

  task automatic test_alu_forward();
    set_in(1, 0, 1, 8, 0, 0, 0, 2'b00); tick();
    set_in(1, 0, 0, 0, 0, 8, 0, 2'b01);
    vecs++; if (fwd_sel[1:0] !== 2'd1 || bubble !== 1'b0) begin errs++; $display("FAIL alu_slot1: got sel=%0d bub=%0b expected sel=1 bub=0", fwd_sel[1:0], bubble); end
    tick();
    set_in(1, 0, 0, 0, 0, 8, 0, 2'b01);
    vecs++; if (fwd_sel[1:0] !== 2'd2) begin errs++; $display("FAIL alu_slot2: got %0d expected 2", fwd_sel[1:0]); end
    tick();
  endtask

  task automatic test_load_use();
    set_in(1, 0, 1, 9, 1, 0, 0, 2'b00); tick();
    set_in(1, 0, 0, 0, 0, 0, 9, 2'b10);
    vecs++; if (bubble !== 1'b1 || fwd_sel !== '0) begin errs++; $display("FAIL load_use_stall: got bub=%0b sel=%0h expected bub=1 sel=0", bubble, fwd_sel); end
    tick();
    set_in(1, 0, 0, 0, 0, 0, 9, 2'b10);
    vecs++; if (bubble !== 1'b0 || fwd_sel[3:2] !== 2'd2) begin errs++; $display("FAIL load_use_fwd: got bub=%0b sel=%0d expected bub=0 sel=2", bubble, fwd_sel[3:2]); end
    vecs++; if (bubble_cnt !== 4'd1) begin errs++; $display("FAIL load_use_cnt: got %0d expected 1", bubble_cnt); end
    tick();
  endtask

  task automatic test_youngest();
    set_in(1, 0, 1, 5, 1, 0, 0, 2'b00); tick();
    set_in(1, 0, 1, 5, 0, 0, 0, 2'b00); tick();
    set_in(1, 0, 0, 0, 0, 5, 0, 2'b01);
    vecs++; if (fwd_sel[1:0] !== 2'd1 || bubble !== 1'b0) begin errs++; $display("FAIL youngest_alu: got sel=%0d bub=%0b expected sel=1 bub=0", fwd_sel[1:0], bubble); end
    tick();
    set_in(1, 0, 1, 6, 0, 0, 0, 2'b00); tick();
    set_in(1, 0, 1, 6, 1, 0, 0, 2'b00); tick();
    set_in(1, 0, 0, 0, 0, 0, 6, 2'b10);
    vecs++; if (bubble !== 1'b1 || fwd_sel !== '0) begin errs++; $display("FAIL youngest_load: got bub=%0b sel=%0h expected bub=1 sel=0", bubble, fwd_sel); end
    tick();
  endtask

  task automatic test_r0();
    set_in(1, 0, 1, 0, 0, 0, 0, 2'b00); tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 2'b11);
    vecs++; if (pending_mask[0] !== 1'b0 || fwd_sel !== '0 || bubble !== 1'b0) begin errs++; $display("FAIL r0: got mask0=%0b sel=%0h bub=%0b expected 0 0 0", pending_mask[0], fwd_sel, bubble); end
    tick();
  endtask

  task automatic test_flush_hold();
    int cnt0;
    set_in(1, 1, 1, 3, 1, 0, 0, 2'b00); tick();
    set_in(1, 0, 0, 0, 0, 3, 3, 2'b11);
    vecs++; if (pending_mask[0] !== 1'b0 || fwd_sel !== '0 || bubble !== 1'b0) begin errs++; $display("FAIL flush_null: got mask0=%0b sel=%0h bub=%0b expected 0 0 0", pending_mask[0], fwd_sel, bubble); end
    tick();
    set_in(1, 0, 1, 7, 1, 0, 0, 2'b00); tick();
    set_in(0, 0, 0, 0, 0, 7, 0, 2'b01);
    cnt0 = mcnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      set_in(0, 0, 0, 0, 0, 7, 0, 2'b01);
      vecs++; if (bubble !== 1'b1 || pending_mask !== 3'b001 || bubble_cnt !== CB'(cnt0)) begin errs++; $display("FAIL hold: got bub=%0b mask=%0b cnt=%0d expected 1 001 %0d", bubble, pending_mask, bubble_cnt, cnt0); end
    end
    set_in(1, 1, 0, 0, 0, 7, 0, 2'b01);
    vecs++; if (bubble !== 1'b1) begin errs++; $display("FAIL flush_bubble: got %0b expected 1", bubble); end
    tick();
    set_in(1, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs++; if (bubble_cnt !== CB'(cnt0) || pending_mask !== 3'b010) begin errs++; $display("FAIL flush_nocount: got cnt=%0d mask=%0b expected %0d 010", bubble_cnt, pending_mask, cnt0); end
    tick();
  endtask

  task automatic test_async_reset();
    set_in(1, 0, 1, 1, 0, 0, 0, 2'b00); tick();
    set_in(1, 0, 1, 2, 0, 0, 0, 2'b00); tick();
    set_in(1, 0, 1, 3, 0, 0, 0, 2'b00); tick();
    #1;
    vecs++; if (pending_mask !== 3'b111) begin errs++; $display("FAIL pre_reset_mask: got %0b expected 111", pending_mask); end
    #1 rst = 1;
    #1;
    vecs++; if (pending_mask !== 3'b000 || bubble_cnt !== '0) begin errs++; $display("FAIL async_reset: got mask=%0b cnt=%0d expected 000 0", pending_mask, bubble_cnt); end
    rst = 0;
    mreset();
    set_in(1, 0, 1, 10, 0, 0, 0, 2'b00); tick();
    set_in(1, 0, 0, 0, 0, 10, 0, 2'b01);
    vecs++; if (pending_mask !== 3'b001 || fwd_sel[1:0] !== 2'd1) begin errs++; $display("FAIL post_reset_load: got mask=%0b sel=%0d expected 001 1", pending_mask, fwd_sel[1:0]); end
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      set_in(1, 0, 1, 11, 1, 0, 0, 2'b00); tick();
      set_in(1, 0, 0, 0, 0, 11, 0, 2'b01);
      vecs++; if (bubble !== 1'b1) begin errs++; $display("FAIL sat_stall: got %0b expected 1", bubble); end
      tick();
    end
    set_in(1, 0, 0, 0, 0, 0, 0, 2'b00);
    vecs++; if (bubble_cnt !== 4'hf || mcnt != CMAX) begin errs++; $display("FAIL saturate: got %0d expected 15", bubble_cnt); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, 1'($urandom), $urandom_range(0, 7),
             1'($urandom), $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom));
      vecs++; if (fwd_sel !== e_sel) begin errs++; $display("FAIL rand_sel: got %0h expected %0h", fwd_sel, e_sel); end
      vecs++; if (bubble !== e_bub) begin errs++; $display("FAIL rand_bubble: got %0b expected %0b", bubble, e_bub); end
      vecs++; if (pending_mask !== e_mask) begin errs++; $display("FAIL rand_mask: got %0b expected %0b", pending_mask, e_mask); end
      vecs++; if (bubble_cnt !== CB'(mcnt)) begin errs++; $display("FAIL rand_cnt: got %0d expected %0d", bubble_cnt, mcnt); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest();
    test_r0();
    test_flush_hold();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
